// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - frame-rate play/obstacle/score controller for the VGA car game
//
// Purpose: sequences IDLE/PLAY/CRASH, scrolls one falling obstacle once per
//   frame, detects obstacle/car overlap and keeps a saturating score.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   frame_start         one-clk pulse at start of vertical blanking
//   start               start button level (rising edge starts a game)
//   score_reset         synchronous score clear (level)
//   speed[1:0]          obstacle step per frame = speed+1 lines
//   car_pos_h[9:0]      car centre column (sampled on frame_start)
//   obs_pos_h/v[9:0]    obstacle centre column / top row
//   obs_valid           obstacle drawn (PLAY only)
//   score[4:0]          0..SCORE_MAX
//   crash, state[1:0]   CRASH flag, 00 IDLE / 01 PLAY / 10 CRASH
// Config macro: OBSTACLE_RANDOM_EN selects LFSR spawn columns instead of the
//   fixed 96/320/544/208 rotation.

module game_sequencer #(
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int CAR_SIZE_H   = 32,
    parameter int CAR_SIZE_V   = 24,
    parameter int OBS_SIZE     = 32,
    parameter int SCORE_MAX    = 19,
    parameter int CRASH_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       start,
    input  logic       score_reset,
    input  logic [1:0] speed,
    input  logic [9:0] car_pos_h,
    output logic [9:0] obs_pos_h,
    output logic [9:0] obs_pos_v,
    output logic       obs_valid,
    output logic [4:0] score,
    output logic       crash,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_CRASH = 2'b10
    } state_t;

    localparam logic [10:0] OBS_HALF   = 11'(OBS_SIZE / 2);
    localparam logic [10:0] OBS_SIDE   = 11'(OBS_SIZE);
    localparam logic [10:0] CAR_HALF   = 11'(CAR_SIZE_H / 2);
    localparam logic [10:0] CAR_TOP    = 11'(V_VISIBLE - CAR_SIZE_V);
    localparam logic [9:0]  V_LIMIT    = 10'(V_VISIBLE);
    localparam logic [9:0]  H_CENTRE   = 10'(H_VISIBLE / 2);
    localparam logic [4:0]  SCORE_TOP  = 5'(SCORE_MAX);
    localparam logic [5:0]  CRASH_LAST = 6'(CRASH_FRAMES - 1);

    state_t      state_q, state_d;
    logic [9:0]  obs_pos_h_q, obs_pos_h_d;
    logic [9:0]  obs_pos_v_q, obs_pos_v_d;
    logic        obs_valid_q, obs_valid_d;
    logic [4:0]  score_q, score_d;
    logic        crash_q, crash_d;
    logic [5:0]  crash_cnt_q, crash_cnt_d;
    logic        start_1d_q, start_1d_d;

    logic        start_edge;
    logic        hit;
    logic        score_inc;
    logic [9:0]  next_v;
    logic [9:0]  spawn_col;

`ifdef OBSTACLE_RANDOM_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16/14/13/11; free-running so spawn depends on play timing.
    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        spawn_col = 10'd64 + {1'b0, lfsr_q[8:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    logic [1:0] spawn_idx_q, spawn_idx_d;
    logic       spawn_take;

    always_comb begin
        case (spawn_idx_q)
            2'd0:    spawn_col = 10'd96;
            2'd1:    spawn_col = 10'd320;
            2'd2:    spawn_col = 10'd544;
            default: spawn_col = 10'd208;
        endcase
        spawn_idx_d = spawn_idx_q + {1'b0, spawn_take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) spawn_idx_q <= 2'd0;
        else        spawn_idx_q <= spawn_idx_d;
    end
`endif

    assign start_edge = start & ~start_1d_q;

    // Overlap test on pre-update positions, widened to 11 bits so the sums
    // near the right/bottom edges cannot wrap.
    assign hit = (({1'b0, obs_pos_h_q} + OBS_HALF) > ({1'b0, car_pos_h} - CAR_HALF)) &
                 (({1'b0, obs_pos_h_q} - OBS_HALF) < ({1'b0, car_pos_h} + CAR_HALF)) &
                 (({1'b0, obs_pos_v_q} + OBS_SIDE) > CAR_TOP);

    assign next_v = obs_pos_v_q + {8'd0, speed} + 10'd1;

    always_comb begin
        state_d     = state_q;
        obs_pos_h_d = obs_pos_h_q;
        obs_pos_v_d = obs_pos_v_q;
        crash_cnt_d = crash_cnt_q;
        start_1d_d  = start;
        score_inc   = 1'b0;
`ifndef OBSTACLE_RANDOM_EN
        spawn_take  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d     = ST_PLAY;
                    obs_pos_v_d = 10'd0;
                    obs_pos_h_d = spawn_col;
`ifndef OBSTACLE_RANDOM_EN
                    spawn_take  = 1'b1;
`endif
                end
            end
            ST_PLAY: begin
                if (frame_start) begin
                    if (hit) begin
                        // Obstacle stays frozen where it hit the car.
                        state_d     = ST_CRASH;
                        crash_cnt_d = 6'd0;
                    end else if (next_v >= V_LIMIT) begin
                        score_inc   = 1'b1;
                        obs_pos_v_d = 10'd0;
                        obs_pos_h_d = spawn_col;
`ifndef OBSTACLE_RANDOM_EN
                        spawn_take  = 1'b1;
`endif
                    end else begin
                        obs_pos_v_d = next_v;
                    end
                end
            end
            ST_CRASH: begin
                if (frame_start) begin
                    if (crash_cnt_q == CRASH_LAST) state_d = ST_IDLE;
                    else                           crash_cnt_d = crash_cnt_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        score_d = score_q;
        if (score_reset)                           score_d = 5'd0;
        else if (score_inc && score_q != SCORE_TOP) score_d = score_q + 5'd1;

        crash_d     = (state_d == ST_CRASH);
        obs_valid_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            obs_pos_h_q <= H_CENTRE;
            obs_pos_v_q <= 10'd0;
            obs_valid_q <= 1'b0;
            score_q     <= 5'd0;
            crash_q     <= 1'b0;
            crash_cnt_q <= 6'd0;
            start_1d_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            obs_pos_h_q <= obs_pos_h_d;
            obs_pos_v_q <= obs_pos_v_d;
            obs_valid_q <= obs_valid_d;
            score_q     <= score_d;
            crash_q     <= crash_d;
            crash_cnt_q <= crash_cnt_d;
            start_1d_q  <= start_1d_d;
        end
    end

    assign obs_pos_h = obs_pos_h_q;
    assign obs_pos_v = obs_pos_v_q;
    assign obs_valid = obs_valid_q;
    assign score     = score_q;
    assign crash     = crash_q;
    assign state     = state_q;

endmodule
